// File: rtl/pgload_pkg.sv
// Shared definitions for the UART program loader.
//   - pgload_state_e : loader FSM states (StChk exists only with PGLOAD_CHECKSUM_EN)
//   - rx_state_e     : UART byte receiver states
//   - SYNC_BYTE      : frame start marker
//   - calc_div()     : clocks per UART bit, rounded to nearest
// Optional feature macro: PGLOAD_CHECKSUM_EN
package pgload_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntL,
        StCntH,
        StDatL,
        StDatH,
`ifdef PGLOAD_CHECKSUM_EN
        StChk,
`endif
        StDone
    } pgload_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   rxd_i       asynchronous serial input, idle high
//   byte_o      last received byte (stable until the next byte completes)
//   valid_o     1-clock pulse, cycle after a good stop-bit sample
//   frame_err_o 1-clock pulse, cycle after a stop-bit sample of 0
module uart_rx_byte
    import pgload_pkg::*;
#(
    parameter int unsigned Div = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned Half = Div / 2;
    localparam int unsigned CntW = $clog2(Div);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RxIdle: begin
                if (prev_q && !sync2_q) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                // Re-check mid start bit; a high line means the edge was a glitch.
                if (cnt_q == CntW'(Half - 1)) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        state_d = RxIdle;
                    end else begin
                        state_d = RxData;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (cnt_q == CntW'(Div - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == CntW'(Div - 1)) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial boot loader: receives a framed program image over 8N1 UART and writes it
// as 16-bit words into the RAM_BIOS download port, holding the CPU in reset meanwhile.
// Frame: A5, count_lo, count_hi, N x (lo, hi), [chk when PGLOAD_CHECKSUM_EN is defined].
// Optional feature macro: PGLOAD_CHECKSUM_EN (mod-256 checksum byte + CHK state).
// Ports:
//   clk      system clock, forwarded on pg_clk_o
//   rst      synchronous active-high reset
//   rxd      UART receive line, idle high
//   pg_clk_o forwarded clock
//   pg_rst   active-low CPU hold, 1 only after a successful load
//   pg_wen   one-clock word write strobe
//   pg_din   word data (valid with pg_wen)
//   pg_adr   word address (valid with pg_wen)
//   pg_done  load complete level
//   err      sticky framing/checksum error, cleared by a sync byte or rst
module uart_prog_loader
    import pgload_pkg::*;
#(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        pg_clk_o,
    output logic        pg_rst,
    output logic        pg_wen,
    output logic [15:0] pg_din,
    output logic [15:0] pg_adr,
    output logic        pg_done,
    output logic        err
);

    localparam int unsigned Div = calc_div(CLK_HZ, BAUD);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_byte #(
        .Div (Div)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    pgload_state_e state_q, state_d;
    logic [7:0]    cnt_lo_q, cnt_lo_d;
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   adr_q, adr_d;
    logic          wen_q, wen_d;
    logic [15:0]   din_q, din_d;
    logic [15:0]   adr_out_q, adr_out_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef PGLOAD_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        rem_d     = rem_q;
        lo_d      = lo_q;
        adr_d     = adr_q;
        wen_d     = 1'b0;
        din_d     = din_q;
        adr_out_d = adr_out_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef PGLOAD_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (rx_ferr) begin
            // Bad byte is dropped; a frame in progress is abandoned.
            err_d = 1'b1;
            if (state_q != StIdle && state_q != StDone) begin
                state_d = StIdle;
            end
        end else if (rx_valid) begin
            case (state_q)
                StIdle, StDone: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = StCntL;
                        err_d   = 1'b0;
                        done_d  = 1'b0;
                        adr_d   = '0;
`ifdef PGLOAD_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                StCntL: begin
                    cnt_lo_d = rx_byte;
                    state_d  = StCntH;
`ifdef PGLOAD_CHECKSUM_EN
                    sum_d    = sum_q + rx_byte;
`endif
                end
                StCntH: begin
                    rem_d = {rx_byte, cnt_lo_q};
`ifdef PGLOAD_CHECKSUM_EN
                    sum_d = sum_q + rx_byte;
`endif
                    if ({rx_byte, cnt_lo_q} == 16'd0) begin
`ifdef PGLOAD_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = StDatL;
                    end
                end
                StDatL: begin
                    lo_d    = rx_byte;
                    state_d = StDatH;
`ifdef PGLOAD_CHECKSUM_EN
                    sum_d   = sum_q + rx_byte;
`endif
                end
                StDatH: begin
                    wen_d     = 1'b1;
                    din_d     = {rx_byte, lo_q};
                    adr_out_d = adr_q;
                    adr_d     = adr_q + 16'd1;
                    rem_d     = rem_q - 16'd1;
`ifdef PGLOAD_CHECKSUM_EN
                    sum_d     = sum_q + rx_byte;
`endif
                    if (rem_q == 16'd1) begin
`ifdef PGLOAD_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = StDatL;
                    end
                end
`ifdef PGLOAD_CHECKSUM_EN
                StChk: begin
                    if (rx_byte == sum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_lo_q  <= '0;
            rem_q     <= '0;
            lo_q      <= '0;
            adr_q     <= '0;
            wen_q     <= 1'b0;
            din_q     <= '0;
            adr_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PGLOAD_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_lo_q  <= cnt_lo_d;
            rem_q     <= rem_d;
            lo_q      <= lo_d;
            adr_q     <= adr_d;
            wen_q     <= wen_d;
            din_q     <= din_d;
            adr_out_q <= adr_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PGLOAD_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign pg_clk_o = clk;
    // CPU is released exactly when a load has completed successfully.
    assign pg_rst   = done_q;
    assign pg_done  = done_q;
    assign pg_wen   = wen_q;
    assign pg_din   = din_q;
    assign pg_adr   = adr_out_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        pg_clk_o;
    logic        pg_rst;
    logic        pg_wen;
    logic [15:0] pg_din;
    logic [15:0] pg_adr;
    logic        pg_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Expected writes as {adr, din}.
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .pg_clk_o (pg_clk_o),
        .pg_rst   (pg_rst),
        .pg_wen   (pg_wen),
        .pg_din   (pg_din),
        .pg_adr   (pg_adr),
        .pg_done  (pg_done),
        .err      (err)
    );

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (pg_wen === 1'b1) begin
            logic [31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wen: got adr=%h din=%h, none expected", pg_adr, pg_din);
            end else begin
                e = exp_q.pop_front();
                if ({pg_adr, pg_din} !== e) begin
                    errors++;
                    $display("FAIL write: got adr=%h din=%h want adr=%h din=%h",
                             pg_adr, pg_din, e[31:16], e[15:0]);
                end
            end
        end
    end

    // 10 clocks per bit (DIV = 10).
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (10) @(negedge clk);
        end
        rxd = stop;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends the bytes; in the checksum build appends sum(bytes[1:]) + chk_adj.
    task automatic send_frame(input byte_q_t b, input logic [7:0] chk_adj);
        logic [7:0] sum;
        sum = 8'h00;
        foreach (b[i]) begin
            send_byte(b[i], 1'b1);
            if (i > 0) sum = sum + b[i];
        end
`ifdef PGLOAD_CHECKSUM_EN
        send_byte(sum + chk_adj, 1'b1);
`endif
        repeat (5) @(negedge clk);
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d outstanding want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (pg_rst !== 1'b0) begin errors++; $display("FAIL reset_pg_rst: got %b want 0", pg_rst); end
        if (pg_wen !== 1'b0) begin errors++; $display("FAIL reset_pg_wen: got %b want 0", pg_wen); end
        if (pg_din !== 16'h0) begin errors++; $display("FAIL reset_pg_din: got %h want 0", pg_din); end
        if (pg_adr !== 16'h0) begin errors++; $display("FAIL reset_pg_adr: got %h want 0", pg_adr); end
        if (pg_done !== 1'b0) begin errors++; $display("FAIL reset_pg_done: got %b want 0", pg_done); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame;
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'h5678});
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56}, 8'h00);
        check_queue_empty("good");
        checks += 3;
        if (pg_done !== 1'b1) begin errors++; $display("FAIL good_done: got %b want 1", pg_done); end
        if (pg_rst !== 1'b1) begin errors++; $display("FAIL good_pg_rst: got %b want 1", pg_rst); end
        if (err !== 1'b0) begin errors++; $display("FAIL good_err: got %b want 0", err); end
    endtask

`ifdef PGLOAD_CHECKSUM_EN
    task automatic test_bad_checksum;
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'h5678});
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56}, 8'h01);
        check_queue_empty("badchk");
        checks += 3;
        if (err !== 1'b1) begin errors++; $display("FAIL badchk_err: got %b want 1", err); end
        if (pg_done !== 1'b0) begin errors++; $display("FAIL badchk_done: got %b want 0", pg_done); end
        if (pg_rst !== 1'b0) begin errors++; $display("FAIL badchk_pg_rst: got %b want 0", pg_rst); end
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'h5678});
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56}, 8'h00);
        check_queue_empty("badchk_retry");
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL badchk_retry_err: got %b want 0", err); end
        if (pg_done !== 1'b1) begin errors++; $display("FAIL badchk_retry_done: got %b want 1", pg_done); end
    endtask
`endif

    task automatic test_framing_error;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (20) @(negedge clk);
        check_queue_empty("ferr");
        checks += 3;
        if (err !== 1'b1) begin errors++; $display("FAIL ferr_err: got %b want 1", err); end
        if (pg_done !== 1'b0) begin errors++; $display("FAIL ferr_done: got %b want 0", pg_done); end
        if (pg_rst !== 1'b0) begin errors++; $display("FAIL ferr_pg_rst: got %b want 0", pg_rst); end
        // Remaining bytes of the broken frame would be ignored in IDLE; start fresh.
        exp_q.push_back({16'h0000, 16'hBEEF});
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE}, 8'h00);
        check_queue_empty("ferr_retry");
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL ferr_retry_err: got %b want 0", err); end
        if (pg_done !== 1'b1) begin errors++; $display("FAIL ferr_retry_done: got %b want 1", pg_done); end
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_queue_empty("glitch");
        checks += 3;
        if (pg_done !== 1'b1) begin errors++; $display("FAIL glitch_done: got %b want 1", pg_done); end
        if (pg_rst !== 1'b1) begin errors++; $display("FAIL glitch_pg_rst: got %b want 1", pg_rst); end
        if (err !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b want 0", err); end
    endtask

    task automatic test_zero_count;
        send_byte(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        checks += 2;
        if (pg_done !== 1'b0) begin errors++; $display("FAIL zero_sync_done: got %b want 0", pg_done); end
        if (pg_rst !== 1'b0) begin errors++; $display("FAIL zero_sync_pg_rst: got %b want 0", pg_rst); end
        send_byte(8'h00, 1'b1);
        send_frame('{8'h00}, 8'h00);
        check_queue_empty("zero");
        checks += 2;
        if (pg_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", pg_done); end
        if (err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_load;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h34, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (pg_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen: got %b want 0", pg_wen); end
        if (pg_din !== 16'h0) begin errors++; $display("FAIL midrst_din: got %h want 0", pg_din); end
        if (pg_adr !== 16'h0) begin errors++; $display("FAIL midrst_adr: got %h want 0", pg_adr); end
        if (pg_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", pg_done); end
        if (pg_rst !== 1'b0) begin errors++; $display("FAIL midrst_pg_rst: got %b want 0", pg_rst); end
        // High byte after reset must not produce a write: FSM is back in IDLE.
        send_byte(8'h12, 1'b1);
        repeat (5) @(negedge clk);
        check_queue_empty("midrst");
        // Back-to-back loads: address restarts at 0 for each.
        exp_q.push_back({16'h0000, 16'h1111});
        exp_q.push_back({16'h0001, 16'h2222});
        exp_q.push_back({16'h0002, 16'h3333});
        send_frame('{8'hA5, 8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33}, 8'h00);
        check_queue_empty("b2b_first");
        exp_q.push_back({16'h0000, 16'hABCD});
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB}, 8'h00);
        check_queue_empty("b2b_second");
        checks += 2;
        if (pg_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", pg_done); end
        if (pg_rst !== 1'b1) begin errors++; $display("FAIL b2b_pg_rst: got %b want 1", pg_rst); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef PGLOAD_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_framing_error();
        test_glitch();
        test_zero_count();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
